// File: rtl/sweeper_pkg.sv
// Shared types and elaboration-time helpers for the window sweeper.
// The helpers build the per-level scale, ratio and hop-bound tables.
package sweeper_pkg;

    typedef enum logic [1:0] {
        IDLE,
        POS,
        PIX,
        DONE
    } state_t;

    // floor(dim * 3^lvl / 4^lvl): pyramid level size
    function automatic int scaled_dim(input int dim, input int lvl);
        longint n;
        longint d;
        n = longint'(dim);
        d = 64'sd1;
        for (int k = 0; k < lvl; k++) begin
            n = n * 3;
            d = d * 4;
        end
        return int'(n / d);
    endfunction

    // Fixed-point scaled-to-source ratio, rounded up by one LSB
    function automatic longint scale_ratio(input int dim, input int sdim,
                                           input int frac);
        return ((longint'(dim) << frac) / longint'(sdim)) + 64'sd1;
    endfunction

    // Largest legal hop origin at this level
    function automatic int sweep_bound(input int sdim, input int win);
        return sdim - win;
    endfunction

endpackage

// File: rtl/sweep_coord_scaler.sv
// Maps a scaled-domain offset to a source-image coordinate.
// Full-width product, then saturation at the last source pixel.
module sweep_coord_scaler #(
    parameter int W      = 6,
    parameter int FRAC_W = 16,
    parameter int MAX    = 40
) (
    input  logic [W-1:0]        offset,
    input  logic [FRAC_W+1:0]   ratio,
    output logic [W-1:0]        coord
);

    localparam int PW = W + FRAC_W + 2;

    logic [PW-1:0] prod;
    logic [W+1:0]  whole;

    assign prod  = PW'(offset) * PW'(ratio);
    assign whole = prod[PW-1:FRAC_W];
    assign coord = (whole > (W+2)'(MAX)) ? W'(MAX) : whole[W-1:0];

endmodule

// File: rtl/window_sweeper.sv
// Multi-scale sliding-window generator: one position token per window,
// then every source-pixel coordinate of that window, with backpressure.
module window_sweeper
    import sweeper_pkg::*;
#(
    parameter int IMG_WIDTH  = 41,
    parameter int IMG_HEIGHT = 50,
    parameter int WIN_W      = 25,
    parameter int WIN_H      = 25,
    parameter int STRIDE_X   = 1,
    parameter int STRIDE_Y   = 2,
    parameter int SCALE_NUM  = 2,
    parameter int FRAC_W     = 16,
    localparam int W_X = $clog2(IMG_WIDTH),
    localparam int W_Y = $clog2(IMG_HEIGHT),
    localparam int W_S = (SCALE_NUM > 1) ? $clog2(SCALE_NUM) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    output logic           busy,
    output logic           done,
    output logic           pos_valid,
    input  logic           pos_ready,
    output logic [W_X-1:0] pos_x,
    output logic [W_Y-1:0] pos_y,
    output logic [W_S-1:0] pos_scale,
    output logic           pos_last,
    output logic           addr_valid,
    input  logic           addr_ready,
    output logic [W_X-1:0] addr_x,
    output logic [W_Y-1:0] addr_y,
    output logic           addr_last
);

    localparam int NTAB = 1 << W_S;
    localparam int RW   = FRAC_W + 2;

    logic [RW-1:0]  ratio_x_tab [NTAB];
    logic [RW-1:0]  ratio_y_tab [NTAB];
    logic [W_X-1:0] bnd_x_tab   [NTAB];
    logic [W_Y-1:0] bnd_y_tab   [NTAB];

    // Unused table slots (non power-of-two level count) mirror level 0
    for (genvar i = 0; i < NTAB; i++) begin : g_lvl
        localparam int LVL = (i < SCALE_NUM) ? i : 0;
        localparam int SW  = scaled_dim(IMG_WIDTH, LVL);
        localparam int SH  = scaled_dim(IMG_HEIGHT, LVL);
        if (SW < WIN_W || SH < WIN_H) begin : g_bad
            $error("window_sweeper: level %0d smaller than window", LVL);
        end
        assign ratio_x_tab[i] = RW'(scale_ratio(IMG_WIDTH, SW, FRAC_W));
        assign ratio_y_tab[i] = RW'(scale_ratio(IMG_HEIGHT, SH, FRAC_W));
        assign bnd_x_tab[i]   = W_X'(sweep_bound(SW, WIN_W));
        assign bnd_y_tab[i]   = W_Y'(sweep_bound(SH, WIN_H));
    end

    state_t         state, state_n;
    logic [W_X-1:0] hop_x, hop_x_n;
    logic [W_Y-1:0] hop_y, hop_y_n;
    logic [W_S-1:0] scale, scale_n;
    logic [W_X-1:0] x_cnt, x_cnt_n;
    logic [W_Y-1:0] y_cnt, y_cnt_n;

    logic wrap_x;
    logic wrap_y;
    logic last_win;
    logic row_end;
    logic win_end;

    assign wrap_x   = (32'(hop_x) + 32'(STRIDE_X)) > 32'(bnd_x_tab[scale]);
    assign wrap_y   = (32'(hop_y) + 32'(STRIDE_Y)) > 32'(bnd_y_tab[scale]);
    assign last_win = (32'(scale) == 32'(SCALE_NUM - 1)) && wrap_x && wrap_y;
    assign row_end  = (x_cnt == W_X'(WIN_W - 1));
    assign win_end  = row_end && (y_cnt == W_Y'(WIN_H - 1));

    // State and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            hop_x <= '0;
            hop_y <= '0;
            scale <= '0;
            x_cnt <= '0;
            y_cnt <= '0;
        end else begin
            state <= state_n;
            hop_x <= hop_x_n;
            hop_y <= hop_y_n;
            scale <= scale_n;
            x_cnt <= x_cnt_n;
            y_cnt <= y_cnt_n;
        end
    end

    // Sweep sequencing: counters move only on an accepted handshake
    always_comb begin
        state_n = state;
        hop_x_n = hop_x;
        hop_y_n = hop_y;
        scale_n = scale;
        x_cnt_n = x_cnt;
        y_cnt_n = y_cnt;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_n = POS;
                    hop_x_n = '0;
                    hop_y_n = '0;
                    scale_n = '0;
                    x_cnt_n = '0;
                    y_cnt_n = '0;
                end
            end
            POS: begin
                if (pos_ready) state_n = PIX;
            end
            PIX: begin
                if (addr_ready) begin
                    if (win_end) begin
                        x_cnt_n = '0;
                        y_cnt_n = '0;
                        if (last_win) begin
                            state_n = DONE;
                        end else begin
                            state_n = POS;
                            if (!wrap_x) begin
                                hop_x_n = hop_x + W_X'(STRIDE_X);
                            end else begin
                                hop_x_n = '0;
                                if (!wrap_y) begin
                                    hop_y_n = hop_y + W_Y'(STRIDE_Y);
                                end else begin
                                    hop_y_n = '0;
                                    scale_n = scale + W_S'(1);
                                end
                            end
                        end
                    end else if (row_end) begin
                        x_cnt_n = '0;
                        y_cnt_n = y_cnt + W_Y'(1);
                    end else begin
                        x_cnt_n = x_cnt + W_X'(1);
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
                hop_x_n = '0;
                hop_y_n = '0;
                scale_n = '0;
            end
            default: state_n = IDLE;
        endcase
    end

    // Status and handshake outputs decoded from state
    always_comb begin
        busy       = (state == POS) || (state == PIX);
        done       = (state == DONE);
        pos_valid  = (state == POS);
        addr_valid = (state == PIX);
        pos_last   = (state == POS) && last_win;
        addr_last  = (state == PIX) && win_end;
    end

    assign pos_x     = hop_x;
    assign pos_y     = hop_y;
    assign pos_scale = scale;

    sweep_coord_scaler #(
        .W      (W_X),
        .FRAC_W (FRAC_W),
        .MAX    (IMG_WIDTH - 1)
    ) u_scale_x (
        .offset (hop_x + x_cnt),
        .ratio  (ratio_x_tab[scale]),
        .coord  (addr_x)
    );

    sweep_coord_scaler #(
        .W      (W_Y),
        .FRAC_W (FRAC_W),
        .MAX    (IMG_HEIGHT - 1)
    ) u_scale_y (
        .offset (hop_y + y_cnt),
        .ratio  (ratio_y_tab[scale]),
        .coord  (addr_y)
    );

endmodule
